// File: rtl/sub_serial_nb.sv
// sub_serial_nb: bit-serial LSB-first subtractor computing R = A - B with borrow-out
module sub_serial_nb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             Bout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             bw, d, nbw;
    logic [CW-1:0]    cnt;

    // full-subtractor stage on the current operand LSBs and the registered borrow
    always_comb begin
        d   = sa[0] ^ sb[0] ^ bw;
        nbw = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    // operand capture, serial shifting and result commit; R/Bout only change on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            bw    <= 1'b0;
            cnt   <= '0;
            R     <= '0;
            Bout  <= 1'b0;
        end else if (state == IDLE) begin
            if (init) begin
                sa    <= A;
                sb    <= B;
                sr    <= '0;
                bw    <= 1'b0;
                cnt   <= '0;
                state <= SHIFT;
            end
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {d, sr[WIDTH-1:1]};
            bw  <= nbw;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                R     <= {d, sr[WIDTH-1:1]};
                Bout  <= nbw;
                state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
